multicycle_cpu_core: RTL

- Parametrised multi-cycle successor to the team's single-cycle MIPS-subset CPU.
- Executes one instruction over several FSM states, sharing a single ALU.
- Fetches through a req/ack instruction-memory port and accesses data through a req/ack data-memory port, so it tolerates multi-cycle ROM/RAM (on-chip M9K or external).
- Holds an internal register file; external memories sit at the top level.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/cpu_regfile.sv | 31 +++
 rtl/multicycle_cpu_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared state/ALU types, ISA constants and decode helpers for the multi-cycle core.
package cpu_pkg;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_t;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluSrl} alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;
    localparam logic [5:0] F_SLL = 6'd0;
    localparam logic [5:0] F_SRL = 6'd2;
    localparam logic [5:0] F_JR  = 6'd8;

    function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_JR: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Non-R-type users of the ALU (addi, lw, sw address) all need an add.
    function automatic alu_op_t alu_decode(input logic [5:0] op, input logic [5:0] funct);
        alu_op_t res;
        res = AluAdd;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SUB:   res = AluSub;
                F_AND:   res = AluAnd;
                F_OR:    res = AluOr;
                F_SLT:   res = AluSlt;
                F_SLL:   res = AluSll;
                F_SRL:   res = AluSrl;
                default: res = AluAdd;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, R0 reads as zero.
module cpu_regfile #(
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    output logic [31:0]              rdata_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [31:0]              rdata_b,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [31:0]              wdata
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle MIPS-subset core sharing one ALU across FETCH/DECODE/EXEC/MEM/WB states.
// Defining CPU_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counter ports.
module multicycle_cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned DADDR_W  = 10,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               MAX10_CLK1_50,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic               retire,
    output logic               halted
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
`endif
);

    localparam int unsigned RAW = $clog2(NREGS);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir, a, b, imm, alu_out, mdr;
    logic [4:0]      shamt;
    alu_op_t         alu_op;

    logic [5:0]      op, funct;
    logic [RAW-1:0]  rs_idx, rt_idx, rd_idx, rf_waddr;
    logic [31:0]     rf_a, rf_b, alu_b, alu_res, rf_wdata;
    logic            rf_we;

    assign op     = ir[31:26];
    assign funct  = ir[5:0];
    assign rs_idx = ir[21 +: RAW];
    assign rt_idx = ir[16 +: RAW];
    assign rd_idx = ir[11 +: RAW];

    // Requests are masked while reset is held so nothing is issued until release.
    assign imem_addr  = pc;
    assign imem_req   = reset && (state == StFetch);
    assign dmem_req   = reset && (state == StMem);
    assign dmem_we    = dmem_req && (op == OP_SW);
    assign dmem_addr  = alu_out[DADDR_W-1:0];
    assign dmem_wdata = b;

    cpu_regfile #(
        .NREGS(NREGS)
    ) u_rf (
        .clk     (MAX10_CLK1_50),
        .reset   (reset),
        .raddr_a (rs_idx),
        .rdata_a (rf_a),
        .raddr_b (rt_idx),
        .rdata_b (rf_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_comb begin
        alu_b = (op == OP_RTYPE) ? b : imm;
        unique case (alu_op)
            AluSub:  alu_res = a - alu_b;
            AluAnd:  alu_res = a & alu_b;
            AluOr:   alu_res = a | alu_b;
            AluSlt:  alu_res = {31'd0, $signed(a) < $signed(alu_b)};
            AluSll:  alu_res = b << shamt;
            AluSrl:  alu_res = b >> shamt;
            default: alu_res = a + alu_b;
        endcase
    end

    // jal links in EXEC; everything else writes back in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state == StWb) begin
            rf_we    = 1'b1;
            rf_waddr = (op == OP_RTYPE) ? rd_idx : rt_idx;
            rf_wdata = (op == OP_LW) ? mdr : alu_out;
        end else if (state == StExec && op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = '1;
            rf_wdata = 32'(pc);
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!reset) begin
            state   <= StFetch;
            pc      <= PC_W'(RESET_PC);
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            shamt   <= '0;
            alu_op  <= AluAdd;
            alu_out <= '0;
            mdr     <= '0;
            retire  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            retire <= 1'b0;
            unique case (state)
                StFetch: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        pc    <= pc + PC_W'(1);
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    a      <= rf_a;
                    b      <= rf_b;
                    imm    <= {{16{ir[15]}}, ir[15:0]};
                    shamt  <= ir[10:6];
                    alu_op <= alu_decode(op, funct);
                    if (insn_legal(op, funct)) begin
                        state <= StExec;
                    end else begin
                        state  <= StTrap;
                        halted <= 1'b1;
                    end
                end
                StExec: begin
                    alu_out <= alu_res;
                    case (op)
                        OP_BEQ, OP_BNE: begin
                            // pc already points past the branch
                            if ((a == b) == (op == OP_BEQ)) pc <= pc + imm[PC_W-1:0];
                            state  <= StFetch;
                            retire <= 1'b1;
                        end
                        OP_J, OP_JAL: begin
                            pc     <= ir[PC_W-1:0];
                            state  <= StFetch;
                            retire <= 1'b1;
                        end
                        OP_LW, OP_SW: state <= StMem;
                        OP_RTYPE: begin
                            if (funct == F_JR) begin
                                pc     <= a[PC_W-1:0];
                                state  <= StFetch;
                                retire <= 1'b1;
                            end else begin
                                state <= StWb;
                            end
                        end
                        default: state <= StWb;
                    endcase
                end
                StMem: begin
                    if (dmem_ack) begin
                        if (op == OP_LW) begin
                            mdr   <= dmem_rdata;
                            state <= StWb;
                        end else begin
                            state  <= StFetch;
                            retire <= 1'b1;
                        end
                    end
                end
                StWb: begin
                    state  <= StFetch;
                    retire <= 1'b1;
                end
                StTrap: halted <= 1'b1;
                default: state <= StFetch;
            endcase
        end
    end

`ifdef CPU_PERF_CNT_EN
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != StTrap) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
